// File: rtl/mem_ctrl_if.sv
// Cache <-> memory bus, split into in/out/oe halves.
// The cache side is the master; the memory model is the slave.
interface mem_ctrl_if #(
  parameter int LINE_W    = 15,
  parameter int DATA_SIZE = 16
);
  logic [LINE_W-1:0]    address;
  logic [DATA_SIZE-1:0] data_in;
  logic [1:0]           cmd_in;
  logic [DATA_SIZE-1:0] data_out;
  logic                 data_oe;
  logic [1:0]           cmd_out;

  modport master (
    output address,
    output data_in,
    output cmd_in,
    input  data_out,
    input  data_oe,
    input  cmd_out
  );

  modport slave (
    input  address,
    input  data_in,
    input  cmd_in,
    output data_out,
    output data_oe,
    output cmd_out
  );
endinterface

// File: rtl/mem_ctrl.sv
// Backing-store model: whole-line read/write bursts with fixed latency.
// Array contents survive reset; an uncommitted write is dropped.
module mem_ctrl #(
  parameter int    MEM_ADDR_SIZE     = 19,
  parameter int    CACHE_OFFSET_SIZE = 4,
  parameter int    DATA_SIZE         = 16,
  parameter int    MEM_LATENCY       = 100,
  parameter string INIT_FILE         = ""
) (
  input logic      clk,
  input logic      rst_n,
  mem_ctrl_if.slave bus
);

  localparam int LINE_W = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
  localparam int BURST_LEN =
    (2 ** CACHE_OFFSET_SIZE) * 8 / DATA_SIZE;
  localparam int K_W = $clog2(BURST_LEN);
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam int WORDS = 2 ** (LINE_W + K_W);

  localparam logic [1:0] CMD_NOP  = 2'd0;
  localparam logic [1:0] CMD_RESP = 2'd1;
  localparam logic [1:0] CMD_RD   = 2'd2;
  localparam logic [1:0] CMD_WR   = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    WR_CAP,
    WAIT,
    RD_BURST
  } state_t;

  state_t               r_state;
  logic [LINE_W-1:0]    r_addr;
  logic                 r_is_wr;
  logic [CNT_W-1:0]     r_cnt;
  logic [K_W:0]         r_k;
  logic [DATA_SIZE-1:0] r_buf [BURST_LEN];
  logic [DATA_SIZE-1:0] r_mem [WORDS];
  logic [DATA_SIZE-1:0] r_data_out;
  logic                 r_oe;
  logic [1:0]           r_cmd_out;

  logic                    w_at_lat;
  logic                    w_commit;
  logic [LINE_W+K_W-1:0]   w_rd_idx;

  // r_cnt holds the number of the edge about to occur, counted from edge 0
  assign w_at_lat = (r_cnt == CNT_W'(MEM_LATENCY));
  assign w_commit = (r_state == WAIT) && r_is_wr && w_at_lat;
  assign w_rd_idx = {r_addr, r_k[K_W-1:0]};

  assign bus.data_out = r_data_out;
  assign bus.data_oe  = r_oe;
  assign bus.cmd_out  = r_cmd_out;

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      r_mem[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < BURST_LEN; i++) begin
        r_mem[{r_addr, K_W'(i)}] <= r_buf[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_is_wr    <= 1'b0;
      r_cnt      <= '0;
      r_k        <= '0;
      r_data_out <= '0;
      r_oe       <= 1'b0;
      r_cmd_out  <= CMD_NOP;
      for (int i = 0; i < BURST_LEN; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      unique case (r_state)
        IDLE: begin
          r_cmd_out  <= CMD_NOP;
          r_oe       <= 1'b0;
          r_data_out <= '0;
          if (bus.cmd_in == CMD_RD || bus.cmd_in == CMD_WR) begin
            r_addr  <= bus.address;
            r_cnt   <= CNT_W'(1);
            r_k     <= '0;
            r_is_wr <= (bus.cmd_in == CMD_WR);
            if (bus.cmd_in == CMD_WR) begin
              r_buf[0] <= bus.data_in;
              r_state  <= WR_CAP;
            end else begin
              r_state  <= WAIT;
            end
          end
        end
        WR_CAP: begin
          r_buf[r_cnt[K_W-1:0]] <= bus.data_in;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(BURST_LEN - 1)) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (w_at_lat) begin
            r_cmd_out <= CMD_RESP;
            if (r_is_wr) begin
              r_state <= IDLE;
            end else begin
              r_oe       <= 1'b1;
              r_data_out <= r_mem[w_rd_idx];
              r_k        <= (K_W+1)'(1);
              r_state    <= RD_BURST;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RD_BURST: begin
          if (r_k == (K_W+1)'(BURST_LEN)) begin
            r_cmd_out  <= CMD_NOP;
            r_oe       <= 1'b0;
            r_data_out <= '0;
            r_state    <= IDLE;
          end else begin
            r_data_out <= r_mem[w_rd_idx];
            r_k        <= r_k + (K_W+1)'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (MEM_LATENCY >= BURST_LEN)
        else $error("mem_ctrl: MEM_LATENCY below burst length");
      assert (bus.cmd_in != CMD_RESP)
        else $error("mem_ctrl: cache drove cmd_in=1");
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: vector table, reset sequences, random ops
// checked against a word-addressed reference store.
module tb_mem_ctrl;

  localparam int LW  = 15;
  localparam int DW  = 16;
  localparam int LAT = 100;
  localparam int BL  = 8;

  typedef logic [BL-1:0][DW-1:0] line_t;

  typedef struct {
    bit          wr;
    logic [LW-1:0] addr;
    line_t       w;
    bit          nz;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic [DW-1:0] model [int];
  vec_t tbl [8];

  always #5 clk = ~clk;

  mem_ctrl_if #(.LINE_W(LW), .DATA_SIZE(DW)) bus ();

  mem_ctrl #(
    .MEM_ADDR_SIZE(19),
    .CACHE_OFFSET_SIZE(4),
    .DATA_SIZE(DW),
    .MEM_LATENCY(LAT),
    .INIT_FILE("")
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic noise(input bit en);
    if (en) begin
      bus.cmd_in  = 2'($urandom_range(2, 3));
      bus.address = LW'($urandom);
      bus.data_in = DW'($urandom);
    end else begin
      bus.cmd_in = 2'd0;
    end
  endtask

  function automatic int widx(input logic [LW-1:0] a, input int k);
    return int'({a, 3'(k)});
  endfunction

  function automatic logic [DW-1:0] mread(input int idx);
    return model.exists(idx) ? model[idx] : '0;
  endfunction

  function automatic line_t ramp(input logic [DW-1:0] b);
    line_t r;
    for (int k = 0; k < BL; k++) r[k] = b + DW'(k);
    return r;
  endfunction

  function automatic line_t model_line(input logic [LW-1:0] a);
    line_t r;
    for (int k = 0; k < BL; k++) r[k] = mread(widx(a, k));
    return r;
  endfunction

  function automatic logic [18:0] outs();
    return {bus.data_oe, bus.cmd_out, bus.data_out};
  endfunction

  task automatic do_write(input logic [LW-1:0] a, input line_t w,
                          input bit nz, input string tag);
    int bad;
    bad = 0;
    bus.cmd_in  = 2'd3;
    bus.address = a;
    bus.data_in = w[0];
    tick();
    for (int k = 1; k < BL; k++) begin
      noise(nz);
      bus.data_in = w[k];
      tick();
      if (bus.cmd_out !== 2'd0 || bus.data_oe !== 1'b0) bad++;
    end
    for (int e = BL; e < LAT; e++) begin
      noise(nz);
      tick();
      if (bus.cmd_out !== 2'd0 || bus.data_oe !== 1'b0) bad++;
    end
    check($sformatf("%s quiet", tag), bad, 0);
    noise(nz);
    tick();
    bus.cmd_in = 2'd0;
    check($sformatf("%s resp", tag),
          {bus.data_oe, bus.cmd_out}, {1'b0, 2'd1});
    tick();
    check($sformatf("%s resp_end", tag),
          {bus.data_oe, bus.cmd_out}, 0);
    for (int k = 0; k < BL; k++) model[widx(a, k)] = w[k];
  endtask

  task automatic do_read(input logic [LW-1:0] a, input line_t exp,
                         input bit nz, input string tag);
    int bad;
    bad = 0;
    bus.cmd_in  = 2'd2;
    bus.address = a;
    tick();
    for (int e = 1; e < LAT; e++) begin
      noise(nz);
      tick();
      if (outs() !== '0) bad++;
    end
    check($sformatf("%s quiet", tag), bad, 0);
    for (int k = 0; k < BL; k++) begin
      noise(nz);
      tick();
      check($sformatf("%s w%0d", tag, k), outs(),
            {1'b1, 2'd1, exp[k]});
    end
    noise(nz);
    tick();
    bus.cmd_in = 2'd0;
    check($sformatf("%s end", tag), outs(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [LW-1:0] a;
    line_t w;
    bit wr;
    bit nz;

    tbl[0] = '{1'b0, 15'h0005, '0,           1'b0};
    tbl[1] = '{1'b1, 15'h0005, ramp(16'h1100), 1'b0};
    tbl[2] = '{1'b0, 15'h0005, ramp(16'h1100), 1'b0};
    tbl[3] = '{1'b1, 15'h7FFF, ramp(16'hF000), 1'b0};
    tbl[4] = '{1'b1, 15'h0000, ramp(16'h0A00), 1'b1};
    tbl[5] = '{1'b0, 15'h7FFF, ramp(16'hF000), 1'b1};
    tbl[6] = '{1'b0, 15'h0000, ramp(16'h0A00), 1'b0};
    tbl[7] = '{1'b0, 15'h0005, ramp(16'h1100), 1'b0};

    bus.cmd_in  = 2'd0;
    bus.address = '0;
    bus.data_in = '0;
    repeat (3) tick();
    check("por outputs", outs(), 0);
    rst_n = 1'b1;
    tick();
    check("idle outputs", outs(), 0);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].wr)
        do_write(tbl[i].addr, tbl[i].w, tbl[i].nz,
                 $sformatf("vec%0d wr", i));
      else
        do_read(tbl[i].addr, tbl[i].w, tbl[i].nz,
                $sformatf("vec%0d rd", i));
    end

    // write aborted by reset at edge 50 must not reach the array
    bus.cmd_in  = 2'd3;
    bus.address = 15'h0010;
    bus.data_in = 16'hAAAA;
    tick();
    bus.cmd_in = 2'd0;
    for (int e = 1; e <= 50; e++) tick();
    rst_n = 1'b0;
    #1;
    check("rst wait outputs", outs(), 0);
    tick();
    rst_n = 1'b1;
    tick();
    do_read(15'h0010, '0, 1'b0, "post-rst rd");

    // reset in the middle of a read burst
    bus.cmd_in  = 2'd2;
    bus.address = 15'h0005;
    tick();
    bus.cmd_in = 2'd0;
    for (int e = 1; e <= LAT + 3; e++) tick();
    check("midburst w3", outs(), {1'b1, 2'd1, 16'h1103});
    rst_n = 1'b0;
    #1;
    check("rst burst outputs", outs(), 0);
    tick();
    check("rst held outputs", outs(), 0);
    rst_n = 1'b1;
    tick();
    do_read(15'h0005, model_line(15'h0005), 1'b0, "fresh rd");

    for (int i = 0; i < 14; i++) begin
      wr = 1'($urandom);
      nz = 1'($urandom);
      case ($urandom_range(0, 3))
        0: a = 15'h0000;
        1: a = 15'h7FFF;
        2: a = 15'h0005;
        default: a = LW'($urandom);
      endcase
      if (wr) begin
        for (int k = 0; k < BL; k++) w[k] = DW'($urandom);
        do_write(a, w, nz, $sformatf("rnd%0d wr", i));
      end else begin
        do_read(a, model_line(a), nz, $sformatf("rnd%0d rd", i));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
